// File: rtl/fir_pkg.sv
// Shared sizes and the state encoding for the FIR control sequencer.
package fir_pkg;

  localparam int NUM_BANKS = 4;
  localparam int TAPS      = 10;
  localparam int GAP_CYC   = 5;
  localparam int DATA_W    = 16;
  localparam int IN_W      = 3;
  localparam int READ_LEN  = 11;
  localparam int CNT_W     = 4;   // must hold max(TAPS, GAP_CYC, READ_LEN) - 1
  localparam int BANK_W    = 2;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    COLLECT = 3'd1,
    PRE     = 3'd2,
    BURST   = 3'd3,
    GAP     = 3'd4,
    READ    = 3'd5
  } state_t;

endpackage

// File: rtl/coeff_bank_buf.sv
// One-bank coefficient buffer: sequential write pointer with full flag and a
// combinational indexed read port used during the replay burst.
module coeff_bank_buf #(
  parameter int TAPS   = 10,
  parameter int DATA_W = 16,
  localparam int IDX_W = $clog2(TAPS)
) (
  input  logic              iClk12M,
  input  logic              iRsn,
  input  logic              iClr,
  input  logic              iWrEn,
  input  logic [DATA_W-1:0] iWrData,
  input  logic [IDX_W-1:0]  iRdIdx,
  output logic [IDX_W-1:0]  oWrPtr,
  output logic              oFull,
  output logic [DATA_W-1:0] oRdData
);

  logic [DATA_W-1:0] mem [TAPS];

  always_ff @(posedge iClk12M) begin
    if (!iRsn || iClr) begin
      oWrPtr <= '0;
      oFull  <= 1'b0;
    end else if (iWrEn && !oFull) begin
      oWrPtr <= oWrPtr + 1'b1;
      oFull  <= (oWrPtr == IDX_W'(TAPS - 1));
    end
  end

  // Storage needs no reset: the pointer alone decides which words are live.
  always_ff @(posedge iClk12M) begin
    if (iWrEn && !oFull) mem[oWrPtr] <= iWrData;
  end

  assign oRdData = (iRdIdx < IDX_W'(TAPS)) ? mem[iRdIdx] : '0;

endmodule

// File: rtl/fir_ctrl_seq.sv
// Sequencer feeding ReConf_FirFilter: collects one coefficient bank at a time,
// replays it as a gap-free write burst, and issues per-sample read windows.
module fir_ctrl_seq
  import fir_pkg::*;
(
  input  logic              iClk12M,
  input  logic              iRsn,
  input  logic              iEnSample600k,
  input  logic [1:0]        iModeSel,
  input  logic [IN_W-1:0]   iSampleIn,
  input  logic              iCoeffLoadReq,
  input  logic              iCoeffValid,
  input  logic [DATA_W-1:0] iCoeffData,
  output logic              oCoeffReady,
  input  logic              iOvrClr,
  output logic              oCoeffUpdateFlag,
  output logic [DATA_W-1:0] oWtDtRam,
  output logic [1:0]        oModuleSel,
  output logic              oMemRdFlag,
  output logic [IN_W-1:0]   oFirIn,
  output logic              oCoeffValid,
  output logic              oLoadDone,
  output logic              oOverrun,
  output state_t            oState
);

  localparam int IDX_W = $clog2(TAPS);

  // Stream handshake: a beat transfers on a rising edge where iCoeffValid and
  // oCoeffReady are both high; ready is high exactly while collecting a bank.
  state_t             state, stateNxt;
  logic [CNT_W-1:0]   cnt, cntNxt;
  logic [BANK_W-1:0]  bank, bankNxt;
  logic               pend, pendNxt;
  logic               readyNxt, flagNxt, memRdNxt, coeffValidNxt, loadDoneNxt, overrunNxt;
  logic [DATA_W-1:0]  wtNxt;
  logic [1:0]         modSelNxt;
  logic [IN_W-1:0]    firInNxt;
  logic               bufClr, bufWr, bufFull;
  logic [IDX_W-1:0]   bufWrPtr;
  logic [DATA_W-1:0]  bufRdData;

  coeff_bank_buf #(.TAPS(TAPS), .DATA_W(DATA_W)) uBuf (
    .iClk12M (iClk12M),
    .iRsn    (iRsn),
    .iClr    (bufClr),
    .iWrEn   (bufWr),
    .iWrData (iCoeffData),
    .iRdIdx  (IDX_W'(cntNxt)),
    .oWrPtr  (bufWrPtr),
    .oFull   (bufFull),
    .oRdData (bufRdData)
  );

  always_comb begin
    stateNxt      = state;
    cntNxt        = cnt;
    bankNxt       = bank;
    pendNxt       = pend;
    coeffValidNxt = oCoeffValid;
    loadDoneNxt   = 1'b0;
    overrunNxt    = oOverrun & ~iOvrClr;
    bufClr        = 1'b0;
    bufWr         = 1'b0;
    unique case (state)
      IDLE: begin
        if (iEnSample600k && oCoeffValid) begin
          stateNxt = READ;
          cntNxt   = '0;
          pendNxt  = pend | iCoeffLoadReq;
        end else if (iCoeffLoadReq || pend) begin
          stateNxt      = COLLECT;
          bankNxt       = '0;
          coeffValidNxt = 1'b0;
          pendNxt       = 1'b0;
          bufClr        = 1'b1;
        end
      end
      COLLECT: begin
        bufWr = iCoeffValid && oCoeffReady && !bufFull;
        if (bufWr && bufWrPtr == IDX_W'(TAPS - 1)) stateNxt = PRE;
      end
      PRE: begin
        stateNxt = BURST;
        cntNxt   = '0;
      end
      BURST: begin
        if (cnt == CNT_W'(TAPS - 1)) begin
          stateNxt = GAP;
          cntNxt   = '0;
        end else begin
          cntNxt = cnt + 1'b1;
        end
      end
      GAP: begin
        if (cnt == CNT_W'(GAP_CYC - 1)) begin
          cntNxt = '0;
          if (bank == BANK_W'(NUM_BANKS - 1)) begin
            stateNxt      = IDLE;
            loadDoneNxt   = 1'b1;
            coeffValidNxt = 1'b1;
          end else begin
            stateNxt = COLLECT;
            bankNxt  = bank + 1'b1;
            bufClr   = 1'b1;
          end
        end else begin
          cntNxt = cnt + 1'b1;
        end
      end
      READ: begin
        // The set term follows the clear term so a same-cycle set wins.
        if (iEnSample600k) overrunNxt = 1'b1;
        if (iCoeffLoadReq) pendNxt = 1'b1;
        if (cnt == CNT_W'(READ_LEN - 1)) begin
          cntNxt = '0;
          if (pend || iCoeffLoadReq) begin
            stateNxt      = COLLECT;
            bankNxt       = '0;
            coeffValidNxt = 1'b0;
            pendNxt       = 1'b0;
            bufClr        = 1'b1;
          end else begin
            stateNxt = IDLE;
          end
        end else begin
          cntNxt = cnt + 1'b1;
        end
      end
      default: stateNxt = IDLE;
    endcase

    // Outputs are registered from the state being entered.
    readyNxt  = (stateNxt == COLLECT);
    flagNxt   = (stateNxt == PRE) || (stateNxt == BURST);
    memRdNxt  = (stateNxt == READ);
    wtNxt     = '0;
    modSelNxt = '0;
    firInNxt  = '0;
    case (stateNxt)
      PRE:   modSelNxt = bankNxt;
      BURST: begin
        modSelNxt = bankNxt;
        wtNxt     = bufRdData;
      end
      READ: begin
        modSelNxt = (state == READ) ? oModuleSel : iModeSel;
        firInNxt  = (state == READ) ? '0 : iSampleIn;
      end
      default: ;
    endcase
  end

  always_ff @(posedge iClk12M) begin
    if (!iRsn) begin
      state            <= IDLE;
      cnt              <= '0;
      bank             <= '0;
      pend             <= 1'b0;
      oCoeffReady      <= 1'b0;
      oCoeffUpdateFlag <= 1'b0;
      oWtDtRam         <= '0;
      oModuleSel       <= '0;
      oMemRdFlag       <= 1'b0;
      oFirIn           <= '0;
      oCoeffValid      <= 1'b0;
      oLoadDone        <= 1'b0;
      oOverrun         <= 1'b0;
    end else begin
      state            <= stateNxt;
      cnt              <= cntNxt;
      bank             <= bankNxt;
      pend             <= pendNxt;
      oCoeffReady      <= readyNxt;
      oCoeffUpdateFlag <= flagNxt;
      oWtDtRam         <= wtNxt;
      oModuleSel       <= modSelNxt;
      oMemRdFlag       <= memRdNxt;
      oFirIn           <= firInNxt;
      oCoeffValid      <= coeffValidNxt;
      oLoadDone        <= loadDoneNxt;
      oOverrun         <= overrunNxt;
    end
  end

  assign oState = state;

endmodule

// File: tb/tb_fir_ctrl_seq.sv
// Directed bench for fir_ctrl_seq: filter-side beats are checked in order
// against an expected queue filled by the stimulus tasks.
module tb_fir_ctrl_seq;
  import fir_pkg::*;

  localparam int EW = 23;  // {flag, memRd, moduleSel, wtDtRam, firIn}

  logic              iClk12M = 1'b0;
  logic              iRsn, iEnSample600k, iCoeffLoadReq, iCoeffValid, iOvrClr;
  logic [1:0]        iModeSel;
  logic [IN_W-1:0]   iSampleIn;
  logic [DATA_W-1:0] iCoeffData;
  logic              oCoeffReady, oCoeffUpdateFlag, oMemRdFlag, oCoeffValid, oLoadDone, oOverrun;
  logic [DATA_W-1:0] oWtDtRam;
  logic [1:0]        oModuleSel;
  logic [IN_W-1:0]   oFirIn;
  state_t            oState;

  // clock / reset
  always #5 iClk12M = ~iClk12M;

  fir_ctrl_seq dut (
    .iClk12M(iClk12M), .iRsn(iRsn), .iEnSample600k(iEnSample600k), .iModeSel(iModeSel),
    .iSampleIn(iSampleIn), .iCoeffLoadReq(iCoeffLoadReq), .iCoeffValid(iCoeffValid),
    .iCoeffData(iCoeffData), .oCoeffReady(oCoeffReady), .iOvrClr(iOvrClr),
    .oCoeffUpdateFlag(oCoeffUpdateFlag), .oWtDtRam(oWtDtRam), .oModuleSel(oModuleSel),
    .oMemRdFlag(oMemRdFlag), .oFirIn(oFirIn), .oCoeffValid(oCoeffValid),
    .oLoadDone(oLoadDone), .oOverrun(oOverrun), .oState(oState)
  );

  int checks = 0;
  int errors = 0;
  logic [EW-1:0] exp_q[$];
  int rise_q[$];
  int cycle = 0, flag_run = 0, rd_run = 0, done_high = 0;
  logic prev_flag = 1'b0;
  logic [EW-1:0] act_beat, exp_beat;

  function automatic logic [DATA_W-1:0] word(input int idx);
    logic [7:0] hi, lo;
    hi = 8'(10 + idx / TAPS);
    lo = 8'(idx % TAPS);
    return {hi, lo};
  endfunction

  function automatic logic [31:0] all_out();
    return 32'({oCoeffReady, oCoeffUpdateFlag, oWtDtRam, oModuleSel, oMemRdFlag,
                oFirIn, oCoeffValid, oLoadDone, oOverrun});
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic push_load_exp();
    for (int b = 0; b < NUM_BANKS; b++) begin
      exp_q.push_back({1'b1, 1'b0, 2'(b), 16'h0000, 3'b000});
      for (int k = 0; k < TAPS; k++)
        exp_q.push_back({1'b1, 1'b0, 2'(b), word(b * TAPS + k), 3'b000});
    end
  endtask

  task automatic push_read_exp(input logic [1:0] mode, input logic [IN_W-1:0] smp);
    exp_q.push_back({1'b0, 1'b1, mode, 16'h0000, smp});
    for (int k = 1; k < READ_LEN; k++)
      exp_q.push_back({1'b0, 1'b1, mode, 16'h0000, 3'b000});
  endtask

  task automatic pulse_strobe(input logic [1:0] mode, input logic [IN_W-1:0] smp);
    @(negedge iClk12M);
    iEnSample600k = 1'b1; iModeSel = mode; iSampleIn = smp;
    @(negedge iClk12M);
    iEnSample600k = 1'b0; iModeSel = 2'b00; iSampleIn = '0;
  endtask

  task automatic pulse_load();
    @(negedge iClk12M); iCoeffLoadReq = 1'b1;
    @(negedge iClk12M); iCoeffLoadReq = 1'b0;
  endtask

  task automatic pulse_clr();
    @(negedge iClk12M); iOvrClr = 1'b1;
    @(negedge iClk12M); iOvrClr = 1'b0;
  endtask

  task automatic stream(input int n, input bit stall);
    int idx = 0;
    int cyc = 0;
    while (idx < n && cyc < 4000) begin
      @(negedge iClk12M);
      iCoeffValid = stall ? (cyc % 2 == 1) : 1'b1;
      iCoeffData  = iCoeffValid ? word(idx) : 16'hdead;
      if (iCoeffValid && oCoeffReady) idx++;
      cyc++;
    end
    @(negedge iClk12M);
    iCoeffValid = 1'b0;
    check("stream_words", 32'(idx), 32'(n));
  endtask

  task automatic wait_load_done(input string name);
    int n = 0;
    while (!oCoeffValid && n < 400) begin
      @(negedge iClk12M);
      n++;
    end
    check(name, 32'(oCoeffValid), 32'd1);
    repeat (3) @(negedge iClk12M);
    check("load_done_pulse", 32'(done_high), 32'd1);
  endtask

  // scoreboard monitor
  always @(negedge iClk12M) begin
    cycle++;
    if (!iRsn) begin
      flag_run  = 0;
      rd_run    = 0;
      prev_flag = 1'b0;
    end else begin
      if (oCoeffUpdateFlag || oMemRdFlag) begin
        act_beat = {oCoeffUpdateFlag, oMemRdFlag, oModuleSel, oWtDtRam, oFirIn};
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat actual=%h expected=none", act_beat);
        end else begin
          exp_beat = exp_q.pop_front();
          if (act_beat !== exp_beat) begin
            errors++;
            $display("FAIL beat actual=%h expected=%h", act_beat, exp_beat);
          end
        end
      end
      if (oCoeffUpdateFlag && !prev_flag) rise_q.push_back(cycle);
      if (oCoeffUpdateFlag) flag_run++;
      else if (flag_run != 0) begin
        checks++;
        if (flag_run != TAPS + 1) begin
          errors++;
          $display("FAIL burst_len actual=%0d expected=%0d", flag_run, TAPS + 1);
        end
        flag_run = 0;
      end
      if (oMemRdFlag) rd_run++;
      else if (rd_run != 0) begin
        checks++;
        if (rd_run != READ_LEN) begin
          errors++;
          $display("FAIL read_len actual=%0d expected=%0d", rd_run, READ_LEN);
        end
        rd_run = 0;
      end
      if (oLoadDone) done_high++;
      prev_flag = oCoeffUpdateFlag;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    iRsn = 1'b0; iEnSample600k = 1'b0; iModeSel = 2'b00; iSampleIn = '0;
    iCoeffLoadReq = 1'b0; iCoeffValid = 1'b0; iCoeffData = '0; iOvrClr = 1'b0;

    // 1. reset with strobes running
    pulse_strobe(2'b11, 3'b101);
    check("reset_outputs_a", all_out(), 32'd0);
    pulse_strobe(2'b01, 3'b011);
    check("reset_outputs_b", all_out(), 32'd0);
    check("reset_state", 32'(oState), 32'(IDLE));
    @(negedge iClk12M); iRsn = 1'b1;

    // 5b. strobe before any load is ignored
    pulse_strobe(2'b10, 3'b111);
    repeat (3) @(negedge iClk12M);
    check("ignored_strobe_rd", 32'(oMemRdFlag), 32'd0);
    check("ignored_strobe_ovr", 32'(oOverrun), 32'd0);
    check("ignored_strobe_state", 32'(oState), 32'(IDLE));

    // 2. full load, no stalls
    done_high = 0;
    rise_q.delete();
    push_load_exp();
    pulse_load();
    stream(NUM_BANKS * TAPS, 1'b0);
    wait_load_done("load_nostall_valid");
    check("burst_count", 32'(rise_q.size()), 32'(NUM_BANKS));
    for (int i = 1; i < rise_q.size(); i++)
      check("bank_spacing", 32'(rise_q[i] - rise_q[i-1]), 32'd26);

    // 4. sample read
    push_read_exp(2'b10, 3'b111);
    pulse_strobe(2'b10, 3'b111);
    repeat (14) @(negedge iClk12M);
    check("read_no_overrun", 32'(oOverrun), 32'd0);

    // next strobe accepted 12 edges later without overrun
    push_read_exp(2'b01, 3'b011);
    push_read_exp(2'b11, 3'b100);
    pulse_strobe(2'b01, 3'b011);
    repeat (11) @(negedge iClk12M);
    pulse_strobe(2'b11, 3'b100);
    repeat (13) @(negedge iClk12M);
    check("b2b_no_overrun", 32'(oOverrun), 32'd0);

    // 5a. overrun, clear, and set-wins-over-clear
    push_read_exp(2'b00, 3'b001);
    pulse_strobe(2'b00, 3'b001);
    repeat (4) @(negedge iClk12M);
    pulse_strobe(2'b11, 3'b110);
    check("overrun_set", 32'(oOverrun), 32'd1);
    repeat (10) @(negedge iClk12M);
    pulse_clr();
    check("overrun_clr", 32'(oOverrun), 32'd0);
    push_read_exp(2'b11, 3'b010);
    pulse_strobe(2'b11, 3'b010);
    repeat (2) @(negedge iClk12M);
    iEnSample600k = 1'b1; iOvrClr = 1'b1;
    @(negedge iClk12M);
    iEnSample600k = 1'b0; iOvrClr = 1'b0;
    check("overrun_set_wins", 32'(oOverrun), 32'd1);
    repeat (10) @(negedge iClk12M);
    pulse_clr();
    check("overrun_clr2", 32'(oOverrun), 32'd0);

    // 3. stalled stream
    done_high = 0;
    push_load_exp();
    pulse_load();
    stream(NUM_BANKS * TAPS, 1'b1);
    wait_load_done("load_stall_valid");

    // 6a. load request during a read window
    done_high = 0;
    push_read_exp(2'b01, 3'b110);
    push_load_exp();
    pulse_strobe(2'b01, 3'b110);
    repeat (2) @(negedge iClk12M);
    pulse_load();
    n = 0;
    while (oMemRdFlag && n < 30) begin
      @(negedge iClk12M);
      n++;
    end
    check("collect_after_read", 32'(oCoeffReady), 32'd1);
    check("valid_cleared", 32'(oCoeffValid), 32'd0);
    stream(NUM_BANKS * TAPS, 1'b0);
    wait_load_done("load_after_read_valid");

    // 6b. reset in the middle of a burst
    push_load_exp();
    pulse_load();
    stream(TAPS, 1'b0);
    n = 0;
    while (!oCoeffUpdateFlag && n < 100) begin
      @(negedge iClk12M);
      n++;
    end
    check("burst_started", 32'(oCoeffUpdateFlag), 32'd1);
    repeat (3) @(negedge iClk12M);
    iRsn = 1'b0;
    @(negedge iClk12M);
    check("midburst_reset_outputs", all_out(), 32'd0);
    exp_q.delete();
    iRsn = 1'b1;
    @(negedge iClk12M);
    check("midburst_reset_state", 32'(oState), 32'(IDLE));
    check("midburst_reset_valid", 32'(oCoeffValid), 32'd0);

    repeat (5) @(negedge iClk12M);
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
